// File: rtl/note_arb_pkg.sv
// Shared types and constants for the note source arbiter.
package note_arb_pkg;

    localparam int NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        LIVE,
        SEQ,
        GAP
    } arb_state_t;

    typedef enum logic {
        SRC_LIVE,
        SRC_SEQ
    } arb_src_t;

endpackage

// File: rtl/arb_down_counter.sv
// Loadable down counter that saturates at zero; load takes priority over decrement.
module arb_down_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/note_source_arbiter.sv
// Shares one voice between live keypad notes and the sequencer, with preemption gaps and a minimum hold.
// Optional NOTE_ARB_RESUME_EN: a released live note hands back to an active sequencer through a gap.
module note_source_arbiter
    import note_arb_pkg::*;
#(
    parameter int MIN_HOLD   = 50,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NOTE_W-1:0] live_note,
    input  logic [NOTE_W-1:0] seq_note,
    input  logic              sequencer_on,
    output logic [NOTE_W-1:0] note_out,
    output logic              src_seq,
    output logic              note_strobe
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_src_t          r_target;
    arb_src_t          w_target_next;
    logic [NOTE_W-1:0] r_note_out;
    logic [NOTE_W-1:0] w_note_next;
    logic              r_note_strobe;
    logic              w_hold_load;
    logic              w_hold_zero;
    logic              w_gap_load;
    logic              w_gap_zero;
    logic              w_live_act;
    logic              w_seq_act;

    assign w_live_act = (live_note != NOTE_SILENT);
    assign w_seq_act  = sequencer_on && (seq_note != NOTE_SILENT);

    arb_down_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_hold_load),
        .load_val (HOLD_INIT),
        .dec      ((r_state == LIVE) || (r_state == SEQ)),
        .zero     (w_hold_zero)
    );

    arb_down_counter #(.WIDTH(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (w_gap_load),
        .load_val (GAP_INIT),
        .dec      (r_state == GAP),
        .zero     (w_gap_zero)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_target      <= SRC_LIVE;
            r_note_out    <= NOTE_SILENT;
            r_note_strobe <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_target      <= w_target_next;
            r_note_out    <= w_note_next;
            r_note_strobe <= (w_note_next != NOTE_SILENT) && (w_note_next != r_note_out);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_note_next   = r_note_out;
        w_hold_load   = 1'b0;
        w_gap_load    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_live_act) begin
                    w_state_next = LIVE;
                    w_note_next  = live_note;
                    w_hold_load  = 1'b1;
                end else if (w_seq_act) begin
                    w_state_next = SEQ;
                    w_note_next  = seq_note;
                    w_hold_load  = 1'b1;
                end
            end
            LIVE: begin
                if (w_live_act && (live_note != r_note_out)) begin
                    w_note_next = live_note;
                    w_hold_load = 1'b1;
                end else if (!w_live_act && w_hold_zero) begin
                    w_note_next  = NOTE_SILENT;
                    w_state_next = IDLE;
`ifdef NOTE_ARB_RESUME_EN
                    if (w_seq_act) begin
                        w_state_next  = GAP;
                        w_gap_load    = 1'b1;
                        w_target_next = SRC_SEQ;
                    end
`endif
                end
            end
            SEQ: begin
                // Live play preempts immediately, ignoring the minimum hold.
                if (w_live_act) begin
                    w_state_next  = GAP;
                    w_note_next   = NOTE_SILENT;
                    w_gap_load    = 1'b1;
                    w_target_next = SRC_LIVE;
                end else if (!sequencer_on) begin
                    w_state_next = IDLE;
                    w_note_next  = NOTE_SILENT;
                end else if ((seq_note != NOTE_SILENT) && (seq_note != r_note_out)) begin
                    w_note_next = seq_note;
                    w_hold_load = 1'b1;
                end else if ((seq_note == NOTE_SILENT) && w_hold_zero) begin
                    w_state_next = IDLE;
                    w_note_next  = NOTE_SILENT;
                end
            end
            GAP: begin
                w_note_next = NOTE_SILENT;
                if (w_gap_zero) begin
                    w_state_next = IDLE;
                    if ((r_target == SRC_LIVE) && w_live_act) begin
                        w_state_next = LIVE;
                        w_note_next  = live_note;
                        w_hold_load  = 1'b1;
                    end else if ((r_target == SRC_SEQ) && w_seq_act) begin
                        w_state_next = SEQ;
                        w_note_next  = seq_note;
                        w_hold_load  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_note_next  = NOTE_SILENT;
            end
        endcase
    end

    assign note_out    = r_note_out;
    assign src_seq     = (r_state == SEQ);
    assign note_strobe = r_note_strobe;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Directed scoreboard bench for note_source_arbiter (MIN_HOLD=4, GAP_CYCLES=2).
module tb_note_source_arbiter;
    import note_arb_pkg::*;

    typedef struct {
        logic [3:0] note;
        logic       src;
        logic       strobe;
        string      tag;
    } exp_t;

    logic       clk;
    logic       n_rst;
    logic [3:0] live_note;
    logic [3:0] seq_note;
    logic       sequencer_on;
    logic [3:0] note_out;
    logic       src_seq;
    logic       note_strobe;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    note_source_arbiter #(.MIN_HOLD(4), .GAP_CYCLES(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .live_note    (live_note),
        .seq_note     (seq_note),
        .sequencer_on (sequencer_on),
        .note_out     (note_out),
        .src_seq      (src_seq),
        .note_strobe  (note_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input logic [3:0] en, input logic es, input logic est, input string tag);
        exp_t e;
        e.note   = en;
        e.src    = es;
        e.strobe = est;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (note_out === e.note) else begin
            n_bad++;
            $error("FAIL %s note_out got %0d want %0d", e.tag, note_out, e.note);
        end
        n_cmp++;
        assert (src_seq === e.src) else begin
            n_bad++;
            $error("FAIL %s src_seq got %0b want %0b", e.tag, src_seq, e.src);
        end
        n_cmp++;
        assert (note_strobe === e.strobe) else begin
            n_bad++;
            $error("FAIL %s note_strobe got %0b want %0b", e.tag, note_strobe, e.strobe);
        end
        $display("t=%0t %s: note_out=%0d src_seq=%0b strobe=%0b", $time, e.tag, note_out, src_seq, note_strobe);
    endtask

    // Drive inputs mid-cycle, expect the registered result after the next rising edge.
    task automatic step(input logic [3:0] l, input logic [3:0] s, input logic on,
                        input logic [3:0] en, input logic es, input logic est, input string tag);
        live_note    = l;
        seq_note     = s;
        sequencer_on = on;
        expect_out(en, es, est, tag);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        n_rst        = 1'b0;
        live_note    = 4'd5;
        seq_note     = 4'd7;
        sequencer_on = 1'b1;
        repeat (3) @(negedge clk);
        expect_out(4'd0, 1'b0, 1'b0, "reset_active_inputs");
        check_out();
        live_note    = 4'd0;
        seq_note     = 4'd0;
        sequencer_on = 1'b0;
        n_rst        = 1'b1;
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_reset");

        // One-cycle live blip is stretched to MIN_HOLD cycles.
        step(4'd5, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1, "live_start");
        step(4'd0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, "blip_hold1");
        step(4'd0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, "blip_hold2");
        step(4'd0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b0, "blip_hold3");
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, "blip_release");
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_quiet");

        // Sequencer plays, live preempts through a two-cycle gap.
        step(4'd0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, "seq_start");
        step(4'd0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, "seq_sustain");
        step(4'd3, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, "preempt_gap1");
        step(4'd3, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, "preempt_gap2");
        step(4'd3, 4'd7, 1'b1, 4'd3, 1'b0, 1'b1, "preempt_live");

        // Legato change reloads the hold, then release after MIN_HOLD.
        step(4'd6, 4'd0, 1'b0, 4'd6, 1'b0, 1'b1, "legato_change");
        step(4'd0, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0, "legato_hold1");
        step(4'd0, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0, "legato_hold2");
        step(4'd0, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0, "legato_hold3");
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, "legato_release");

        // Simultaneous live and sequencer from IDLE: live wins.
        step(4'd2, 4'd7, 1'b1, 4'd2, 1'b0, 1'b1, "both_live_wins");
        step(4'd2, 4'd7, 1'b1, 4'd2, 1'b0, 1'b0, "both_live_holds");

        // Live release while the sequencer is waiting with note 9.
        step(4'd3, 4'd9, 1'b1, 4'd3, 1'b0, 1'b1, "resume_live3");
        step(4'd0, 4'd9, 1'b1, 4'd3, 1'b0, 1'b0, "resume_hold1");
        step(4'd0, 4'd9, 1'b1, 4'd3, 1'b0, 1'b0, "resume_hold2");
        step(4'd0, 4'd9, 1'b1, 4'd3, 1'b0, 1'b0, "resume_hold3");
`ifdef NOTE_ARB_RESUME_EN
        step(4'd0, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, "resume_gap1");
        step(4'd0, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, "resume_gap2");
        step(4'd0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1, "resume_seq9");
`else
        step(4'd0, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0, "restart_idle");
        step(4'd0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1, "restart_seq9");
        step(4'd0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, "restart_sustain");
`endif

        // In-source sequencer change, then sequencer_on drops without waiting for hold.
        step(4'd0, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, "seq_change7");
        step(4'd0, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, "seq_off_drop");

        // Sequencer note release honours the minimum hold.
        step(4'd0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, "seq_blip_start");
        step(4'd0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, "seq_blip_hold1");
        step(4'd0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, "seq_blip_hold2");
        step(4'd0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, "seq_blip_hold3");
        step(4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, "seq_blip_release");

        // Asynchronous reset mid-note clears outputs without a clock edge.
        step(4'd4, 4'd0, 1'b0, 4'd4, 1'b0, 1'b1, "pre_reset_live4");
        n_rst = 1'b0;
        #1;
        expect_out(4'd0, 1'b0, 1'b0, "async_reset_mid");
        check_out();
        live_note = 4'd0;
        @(negedge clk);
        n_rst = 1'b1;
        step(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_reset2");
        step(4'd8, 4'd0, 1'b0, 4'd8, 1'b0, 1'b1, "live_after_reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
